// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode output,
// back-pressure and branch redirect.
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        stall_in;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic        inst_valid;

   modport master (
      output imem_addr, imem_req, inst_out, pc_out, inst_valid,
      input  imem_rdata, imem_ready, stall_in, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_addr, imem_req, inst_out, pc_out, inst_valid,
      output imem_rdata, imem_ready, stall_in, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC ownership, handshaked memory fetch with a
// one-entry skid buffer for decode back-pressure, and redirect/drain handling.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_stage_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

   state_t      r_state, w_state;
   logic [31:0] r_pc, w_pc;
   logic [31:0] r_tgt, w_tgt;
   logic [31:0] r_inst, w_inst;
   logic [31:0] r_pc_out, w_pc_out;
   logic        r_valid, w_valid;
   logic [31:0] r_skid_inst, w_skid_inst;
   logic [31:0] r_skid_pc, w_skid_pc;
   logic        w_consume;
   logic        w_slot_free;

   assign bus.imem_addr  = r_pc;
   assign bus.imem_req   = (r_state == S_REQ) || (r_state == S_DRAIN);
   assign bus.inst_out   = r_inst;
   assign bus.pc_out     = r_pc_out;
   assign bus.inst_valid = r_valid;

   assign w_consume   = r_valid & ~bus.stall_in;
   assign w_slot_free = ~r_valid | ~bus.stall_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_PC;
         r_tgt       <= RESET_PC;
         r_inst      <= '0;
         r_pc_out    <= '0;
         r_valid     <= 1'b0;
         r_skid_inst <= '0;
         r_skid_pc   <= '0;
      end else begin
         r_pc        <= w_pc;
         r_tgt       <= w_tgt;
         r_inst      <= w_inst;
         r_pc_out    <= w_pc_out;
         r_valid     <= w_valid;
         r_skid_inst <= w_skid_inst;
         r_skid_pc   <= w_skid_pc;
      end
   end

   // While draining, the target is parked in r_tgt so imem_addr (== r_pc)
   // stays on the outstanding address until the old response arrives.
   always_comb begin
      w_state     = r_state;
      w_pc        = r_pc;
      w_tgt       = r_tgt;
      w_inst      = r_inst;
      w_pc_out    = r_pc_out;
      w_valid     = r_valid;
      w_skid_inst = r_skid_inst;
      w_skid_pc   = r_skid_pc;
      if (bus.redirect_valid) begin
         w_valid = 1'b0;
         if (((r_state == S_REQ) || (r_state == S_DRAIN)) && !bus.imem_ready) begin
            w_state = S_DRAIN;
            w_tgt   = bus.redirect_pc;
         end else begin
            w_state = S_REQ;
            w_pc    = bus.redirect_pc;
         end
      end else begin
         if (w_consume) w_valid = 1'b0;
         unique case (r_state)
            S_IDLE: w_state = S_REQ;
            S_REQ: begin
               if (bus.imem_ready) begin
                  w_pc = r_pc + PC_STEP;
                  if (w_slot_free) begin
                     w_inst   = bus.imem_rdata;
                     w_pc_out = r_pc;
                     w_valid  = 1'b1;
                  end else begin
                     w_skid_inst = bus.imem_rdata;
                     w_skid_pc   = r_pc;
                     w_state     = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!bus.stall_in) begin
                  w_inst   = r_skid_inst;
                  w_pc_out = r_skid_pc;
                  w_valid  = 1'b1;
                  w_state  = S_REQ;
               end
            end
            S_DRAIN: begin
               if (bus.imem_ready) begin
                  w_pc    = r_tgt;
                  w_state = S_REQ;
               end
            end
            default: w_state = S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: hand-derived vector table, queue-based
// reference model over wait-state/random traffic, async reset and PC wrap.
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst_n;
   logic rst_nw;
   always #5 clk = ~clk;

   fetch_stage_if bus ();
   fetch_stage_if bw ();

   fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.master)
   );
   fetch_stage #(.RESET_PC(32'hFFFF_FFFE), .PC_STEP(32'd1)) dut_w (
      .clk(clk), .rst_n(rst_nw), .bus(bw.master)
   );

   // Memory returns address + 0x100 as the instruction word.
   assign bus.imem_rdata     = bus.imem_addr + 32'h100;
   assign bw.imem_rdata      = bw.imem_addr + 32'h100;
   assign bw.imem_ready      = 1'b1;
   assign bw.stall_in        = 1'b0;
   assign bw.redirect_valid  = 1'b0;
   assign bw.redirect_pc     = '0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   typedef struct {
      logic        stall;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic        ereq;
      logic [31:0] eaddr;
   } vec_t;

   typedef enum {M_IDLE, M_REQ, M_HOLD, M_DRAIN} mstate_t;

   mstate_t     m_state;
   logic [31:0] m_pc;
   logic [31:0] m_tgt;
   ent_t        q[$];
   int          n_checks = 0;
   int          n_err = 0;
   vec_t        tbl[31];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_state = M_IDLE;
      m_pc    = 32'h0;
      m_tgt   = 32'h0;
      q.delete();
   endfunction

   // Reference model advanced once per rising edge from the driven inputs.
   task automatic model_step();
      bit   consume;
      ent_t e;
      if (!rst_n) begin
         model_reset();
         return;
      end
      consume = (q.size() != 0) && !bus.stall_in;
      if (bus.redirect_valid) begin
         q.delete();
         if (((m_state == M_REQ) || (m_state == M_DRAIN)) && !bus.imem_ready) begin
            m_state = M_DRAIN;
            m_tgt   = bus.redirect_pc;
         end else begin
            m_state = M_REQ;
            m_pc    = bus.redirect_pc;
         end
      end else begin
         if (consume) void'(q.pop_front());
         case (m_state)
            M_IDLE: m_state = M_REQ;
            M_REQ: begin
               if (bus.imem_ready) begin
                  e.inst = m_pc + 32'h100;
                  e.pc   = m_pc;
                  q.push_back(e);
                  m_pc = m_pc + 32'd1;
                  if (q.size() == 2) m_state = M_HOLD;
               end
            end
            M_HOLD:  if (consume) m_state = M_REQ;
            M_DRAIN: begin
               if (bus.imem_ready) begin
                  m_pc    = m_tgt;
                  m_state = M_REQ;
               end
            end
            default: m_state = M_IDLE;
         endcase
      end
   endtask

   task automatic model_check();
      chk("inst_valid", bus.inst_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("inst_out", bus.inst_out, q[0].inst);
         chk("pc_out", bus.pc_out, q[0].pc);
      end
      chk("imem_req", bus.imem_req, (m_state == M_REQ) || (m_state == M_DRAIN));
      chk("imem_addr", bus.imem_addr, m_pc);
   endtask

   task automatic drive(input logic stall, input logic ready, input logic redir, input logic [31:0] rpc);
      bus.stall_in       = stall;
      bus.imem_ready     = ready;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      model_check();
   endtask

   initial begin
      //        stall ready redir rpc       ev   epc        ereq addr
      tbl = '{
         '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h00},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 1'b1, 32'h01},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h01, 1'b1, 32'h02},
         '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h01, 1'b0, 32'h03},
         '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h01, 1'b0, 32'h03},
         '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h01, 1'b0, 32'h03},
         '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h01, 1'b0, 32'h03},
         '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h02, 1'b1, 32'h03},
         '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h03},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h03, 1'b1, 32'h04},
         '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h04},
         '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h04},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 1'b1, 32'h05},
         '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h05},
         '{1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h00, 1'b1, 32'h05},
         '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h05},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h40},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h40, 1'b1, 32'h41},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h41, 1'b1, 32'h42},
         '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h41, 1'b0, 32'h43},
         '{1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h00, 1'b1, 32'h80},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h80, 1'b1, 32'h81},
         '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h81},
         '{1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h00, 1'b1, 32'h10},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10, 1'b1, 32'h11},
         '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h11},
         '{1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h00, 1'b1, 32'h11},
         '{1'b0, 1'b0, 1'b1, 32'h30, 1'b0, 32'h00, 1'b1, 32'h11},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h30},
         '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h30, 1'b1, 32'h31},
         '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h31}
      };

      rst_n  = 1'b0;
      rst_nw = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0);
      model_reset();
      tick();
      tick();
      chk("reset inst_out", bus.inst_out, 32'h0);
      chk("reset pc_out", bus.pc_out, 32'h0);

      rst_n = 1'b1;
      for (int i = 0; i < 31; i++) begin
         drive(tbl[i].stall, tbl[i].ready, tbl[i].redir, tbl[i].rpc);
         tick();
         chk($sformatf("tbl%0d valid", i), bus.inst_valid, tbl[i].ev);
         if (tbl[i].ev) chk($sformatf("tbl%0d pc_out", i), bus.pc_out, tbl[i].epc);
         chk($sformatf("tbl%0d req", i), bus.imem_req, tbl[i].ereq);
         chk($sformatf("tbl%0d addr", i), bus.imem_addr, tbl[i].eaddr);
      end

      for (int i = 0; i < 30; i++) begin
         drive(1'b0, (i % 3) == 2, 1'b0, '0);
         tick();
      end

      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 15) == 0, $urandom);
         tick();
      end

      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, 1'b0, '0);
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst valid", bus.inst_valid, 1'b0);
      chk("async rst inst_out", bus.inst_out, 32'h0);
      chk("async rst pc_out", bus.pc_out, 32'h0);
      chk("async rst req", bus.imem_req, 1'b0);
      chk("async rst addr", bus.imem_addr, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("restart valid", bus.inst_valid, 1'b1);
      chk("restart pc_out", bus.pc_out, 32'h0);

      @(negedge clk);
      rst_nw = 1'b1;
      @(posedge clk); #1;
      chk("wrap idle valid", bw.inst_valid, 1'b0);
      @(posedge clk); #1;
      chk("wrap pc0", bw.pc_out, 32'hFFFF_FFFE);
      chk("wrap inst0", bw.inst_out, 32'h0000_00FE);
      @(posedge clk); #1;
      chk("wrap pc1", bw.pc_out, 32'hFFFF_FFFF);
      chk("wrap inst1", bw.inst_out, 32'h0000_00FF);
      @(posedge clk); #1;
      chk("wrap pc2", bw.pc_out, 32'h0000_0000);
      chk("wrap inst2", bw.inst_out, 32'h0000_0100);
      chk("wrap valid", bw.inst_valid, 1'b1);
      #2;
      rst_nw = 1'b0;
      #1;
      chk("wrap rst valid", bw.inst_valid, 1'b0);
      chk("wrap rst pc_out", bw.pc_out, 32'h0);
      chk("wrap rst addr", bw.imem_addr, 32'hFFFF_FFFE);
      @(negedge clk);
      rst_nw = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      chk("wrap restart pc", bw.pc_out, 32'hFFFF_FFFE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
